fpga_robots_game_cell_writer: RTL and testbench
===============================================

// Module: fpga_robots_game_cell_writer
// PURPOSE
//   Tile map client that updates individual 8x8 play-area cells (2-bit contents: blank, robot, trash, player).
//   Game logic queues cell writes (x, y, what); this block runs a read-modify-write on the packed tile map byte
//   through the video generator's external port (tm_adr/tm_red/tm_wrt/tm_wen).
//   The other 6 bits of each byte are preserved. By default writes start only during the VBI, so no frame tears.
// PARAMETERS
//   FIFO_AW   3  log2 of command FIFO depth (default 8 entries)
//   VBI_ONLY  1  1: start an RMW only while vbi=1; 0: start whenever the FIFO is non-empty
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst        in   1   synchronous reset, active-high
//   cmd_valid  in   1   command offered this cycle
//   cmd_ready  out  1   command accepted when cmd_valid && cmd_ready
//   cmd_x      in   7   cell column, 0-119 legal
//   cmd_y      in   7   cell row, 0-95 legal
//   cmd_what   in   2   new cell contents
//   cmd_err    out  1   one-cycle pulse: accepted command was out of range and dropped
//   vbi        in   1   vertical blanking indication from the video generator
//   tm_adr     out  13  tile map address
//   tm_red     in   8   tile map read data, valid one clock after tm_adr
//   tm_wrt     out  8   tile map write data
//   tm_wen     out  1   tile map write enable
//   busy       out  1   FIFO non-empty or RMW in progress
//   done       out  1   one-cycle pulse when an RMW write cycle completes
// BEHAVIOUR
// - Reset values: tm_adr=0, tm_wrt=0, tm_wen=0, cmd_err=0, done=0, busy=0, cmd_ready=1. FIFO empty, state IDLE.
//   All tm_* outputs, cmd_err and done are registered.
// - Accept and range check:
//   - cmd_ready = !fifo_full. A push is judged on fullness at the start of the cycle, even if a pop happens in the same cycle.
//   - Range check is done at accept time. If x>=120 or y>=96, the command is not queued and cmd_err pulses the next cycle.
// - Address and merge:
//   - Byte address = {cmd_y[6:1], cmd_x[6:0]}.
//   - Even y: new byte = {old[7:2], what}.
//   - Odd y: new byte = {old[7:4], what, old[1:0]}.
// - FSM, 4 cycles per command:
//   - IDLE: if FIFO non-empty && (vbi || !VBI_ONLY): pop the head, tm_adr <= addr, tm_wen <= 0, go to RD.
//   - RD: tm_adr is held on the port while the memory captures tm_red. Go to MOD.
//   - MOD: tm_red is valid. tm_wrt <= merged byte, tm_wen <= 1. Go to WR.
//   - WR: the write takes effect at the end of this cycle. tm_wen <= 0, done <= 1. Go to IDLE.
//   - tm_adr holds its value from RD through WR.
// - vbi only gates the start of an RMW. If vbi falls mid-operation, the current RMW completes.
// - Same-byte commands back to back are coherent: the next read is issued only after the previous write cycle.
// - FIFO pointers are FIFO_AW+1 bits with wrap. Full when pointer MSBs differ and the rest are equal; empty when pointers are equal.
// - busy = !empty || state != IDLE.
// - Reset mid-operation: the FSM returns to IDLE and the FIFO is flushed. tm_wen is 0 from the next cycle, so no partial write issues.
// TESTING
//   1 Hold rst 3 cycles, then release -> tm_wen=0, cmd_ready=1, busy=0, done=0.
//   2 Byte 0x185 = 0xA1, vbi=1, push (x=5,y=7,what=2):
//     -> tm_adr=0x185; one tm_wen cycle with tm_wrt=0xA9; done pulses; busy falls.
//   3 VBI_ONLY=1, vbi=0, push one command -> no tm_wen for 100 cycles, busy=1.
//     Then raise vbi -> tm_wen within 4 cycles.
//   4 vbi=0, push 9 commands -> 8 accepted, cmd_ready=0 on the 9th.
//     Then raise vbi -> exactly 8 write cycles; cmd_ready returns to 1.
//   5 Byte 0x000 = 0xF0, push (0,0,1) then (0,1,3), vbi=1 -> writes 0xF1 then 0xFD; final byte 0xFD.
//   6 Push (x=120,y=0) and (x=0,y=96) -> cmd_err pulses twice, no tm_wen.
//     Assert rst during the MOD state -> no write, FIFO empty afterwards.

Source files
------------

// File: rtl/fpga_robots_game_cell_writer.sv
// Queued 2-bit play-area cell writer: read-modify-write of packed tile map bytes
// through the video generator's external port, optionally only during vertical blanking.
module fpga_robots_game_cell_writer #(
  parameter int FIFO_AW  = 3,
  parameter bit VBI_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [1:0]  cmd_what,
  output logic        cmd_err,
  input  logic        vbi,
  output logic [12:0] tm_adr,
  input  logic [7:0]  tm_red,
  output logic [7:0]  tm_wrt,
  output logic        tm_wen,
  output logic        busy,
  output logic        done
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, RD, MOD, WR} state_t;

  // FIFO entry: {byte address, odd row, new contents}
  logic [15:0]        fifo [DEPTH];
  logic [FIFO_AW:0]   wptr, rptr;
  logic               full, empty, in_range, push, pop;
  logic [15:0]        head;
  state_t             state, state_n;
  logic               cur_odd;
  logic [1:0]         cur_what;
  logic [12:0]        adr_n;
  logic [7:0]         wrt_n;
  logic               wen_n, done_n;

  assign full      = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign empty     = (wptr == rptr);
  assign cmd_ready = !full;
  assign in_range  = (cmd_x < 7'd120) && (cmd_y < 7'd96);
  assign push      = cmd_valid && cmd_ready && in_range;
  assign head      = fifo[rptr[FIFO_AW-1:0]];
  assign pop       = (state == IDLE) && !empty && (vbi || !VBI_ONLY);
  assign busy      = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo[wptr[FIFO_AW-1:0]] <= {cmd_y[6:1], cmd_x, cmd_y[0], cmd_what};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cmd_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cmd_err <= cmd_valid && cmd_ready && !in_range;
    end
  end

  // State register; the port outputs are registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tm_adr   <= '0;
      tm_wrt   <= '0;
      tm_wen   <= 1'b0;
      done     <= 1'b0;
      cur_odd  <= 1'b0;
      cur_what <= '0;
    end else begin
      state  <= state_n;
      tm_adr <= adr_n;
      tm_wrt <= wrt_n;
      tm_wen <= wen_n;
      done   <= done_n;
      if (pop) begin
        cur_odd  <= head[2];
        cur_what <= head[1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = RD;
      RD:      state_n = MOD;
      MOD:     state_n = WR;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    adr_n  = tm_adr;
    wrt_n  = tm_wrt;
    wen_n  = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (pop) adr_n = head[15:3];
      MOD: begin
        wrt_n = cur_odd ? {tm_red[7:4], cur_what, tm_red[1:0]}
                        : {tm_red[7:2], cur_what};
        wen_n = 1'b1;
      end
      WR:      done_n = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fpga_robots_game_cell_writer.sv
// Directed + randomized bench for the cell writer against a tile-map memory and a
// byte-array reference model of the play area.
module tb_fpga_robots_game_cell_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x = '0, cmd_y = '0;
  logic [1:0]  cmd_what = '0;
  logic        cmd_err;
  logic        vbi = 1'b0;
  logic [12:0] tm_adr;
  logic [7:0]  tm_red;
  logic [7:0]  tm_wrt;
  logic        tm_wen;
  logic        busy;
  logic        done;

  fpga_robots_game_cell_writer #(.FIFO_AW(3), .VBI_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_what(cmd_what), .cmd_err(cmd_err),
    .vbi(vbi), .tm_adr(tm_adr), .tm_red(tm_red), .tm_wrt(tm_wrt),
    .tm_wen(tm_wen), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Tile map memory with one-cycle read latency and a bench-side preload path
  logic [7:0]  mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_adr = '0;
  logic [7:0]  pl_dat = '0;
  int          wen_count = 0;
  logic [7:0]  wq [$];

  always @(posedge clk) begin
    tm_red <= mem[tm_adr];
    if (tm_wen) mem[tm_adr] <= tm_wrt;
    if (pl_en)  mem[pl_adr] <= pl_dat;
  end

  always @(posedge clk) begin
    if (tm_wen) begin
      wen_count <= wen_count + 1;
      wq.push_back(tm_wrt);
    end
  end

  logic [7:0] exp_m [0:8191];
  int n_pass = 0, n_total = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: cell (x,y) lives in byte (y/2)*128+x, at bit 0 (even y) or bit 2 (odd y)
  function automatic void apply(input int x, input int y, input int w);
    int a, sh;
    a  = (y / 2) * 128 + x;
    sh = (y % 2) * 2;
    exp_m[a] = 8'((int'(exp_m[a]) & ~(3 << sh)) | (w << sh));
  endfunction

  task automatic preload(input int a, input int d);
    pl_en = 1'b1; pl_adr = 13'(a); pl_dat = 8'(d);
    tick();
    pl_en = 1'b0;
    exp_m[a] = 8'(d);
  endtask

  task automatic push(input int x, input int y, input int w, input bit model, output bit acc);
    bit bad;
    cmd_valid = 1'b1; cmd_x = 7'(x); cmd_y = 7'(y); cmd_what = 2'(w);
    acc = cmd_ready;
    bad = (x >= 120) || (y >= 96);
    tick();
    cmd_valid = 1'b0;
    check("cmd_err", cmd_err, acc && bad);
    if (acc && !bad && model) apply(x, y, w);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    check("drain_idle", busy, 1'b0);
  endtask

  function automatic int mem_mismatches();
    int m = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== exp_m[i]) m++;
    return m;
  endfunction

  initial begin
    bit acc;
    int w0, n, x, y;
    bit seen;
    for (int i = 0; i < 8192; i++) begin mem[i] = 8'h00; exp_m[i] = 8'h00; end

    // 1: reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tm_wen", tm_wen, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tm_adr", tm_adr, 13'h0);
    check("rst_cmd_err", cmd_err, 1'b0);

    // Random background for the region the random phase touches
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++) preload(yy * 128 + xx, int'($urandom_range(255)));
    preload(47 * 128 + 119, int'($urandom_range(255)));

    // 2: single RMW on byte 0x185
    preload(13'h185, 8'hA1);
    vbi = 1'b1;
    push(5, 7, 2, 1'b1, acc);
    n = 0;
    while (!tm_wen && n < 10) begin tick(); n++; end
    check("t2_wen_seen", tm_wen, 1'b1);
    check("t2_adr", tm_adr, 13'h185);
    check("t2_wrt", tm_wrt, 8'hA9);
    check("t2_done_during_wr", done, 1'b0);
    tick();
    check("t2_wen_off", tm_wen, 1'b0);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    tick();
    check("t2_done_pulse", done, 1'b0);
    check("t2_mem", mem[13'h185], 8'hA9);

    // 3: no start outside VBI
    vbi = 1'b0;
    w0 = wen_count;
    push(int'($urandom_range(7)), int'($urandom_range(15)), int'($urandom_range(3)), 1'b1, acc);
    repeat (100) tick();
    check("t3_no_wen", wen_count, w0);
    check("t3_busy", busy, 1'b1);
    vbi = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin tick(); if (tm_wen) seen = 1'b1; end
    check("t3_wen_in_4", seen, 1'b1);
    drain(20);

    // 4: fill FIFO, ninth command refused
    vbi = 1'b0;
    w0 = wen_count;
    for (int i = 0; i < 9; i++) begin
      x = int'($urandom_range(7)); y = int'($urandom_range(15));
      check("t4_ready", cmd_ready, (i < 8) ? 1'b1 : 1'b0);
      push(x, y, int'($urandom_range(3)), (i < 8), acc);
    end
    check("t4_busy", busy, 1'b1);
    vbi = 1'b1;
    drain(100);
    check("t4_writes", wen_count - w0, 8);
    check("t4_ready_back", cmd_ready, 1'b1);
    check("t4_mem", mem_mismatches(), 0);

    // 5: back-to-back same byte
    preload(0, 8'hF0);
    wq.delete();
    push(0, 0, 1, 1'b1, acc);
    push(0, 1, 3, 1'b1, acc);
    drain(30);
    check("t5_nwrites", wq.size(), 2);
    check("t5_wr0", (wq.size() > 0) ? wq[0] : 8'hxx, 8'hF1);
    check("t5_wr1", (wq.size() > 1) ? wq[1] : 8'hxx, 8'hFD);
    check("t5_mem", mem[0], 8'hFD);

    // 6: out-of-range commands dropped, then reset during MOD
    w0 = wen_count;
    push(120, 0, 1, 1'b1, acc);
    push(0, 96, 2, 1'b1, acc);
    tick();
    check("t6_err_clear", cmd_err, 1'b0);
    repeat (6) tick();
    check("t6_no_wen", wen_count, w0);
    check("t6_busy", busy, 1'b0);
    push(3, 2, 1, 1'b0, acc);
    push(4, 2, 2, 1'b0, acc);
    tick();
    check("t6_in_mod_wen", tm_wen, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_rst_wen", tm_wen, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (8) tick();
    check("t6_no_partial", wen_count, w0);
    check("t6_flushed", busy, 1'b0);
    check("t6_mem", mem_mismatches(), 0);

    // Randomized traffic with vbi toggling
    for (int i = 0; i < 300; i++) begin
      vbi = 1'($urandom_range(1));
      if ($urandom_range(2) != 0) begin
        case ($urandom_range(9))
          0:       x = int'($urandom_range(127, 120));
          1:       x = 119;
          default: x = int'($urandom_range(7));
        endcase
        case ($urandom_range(9))
          0:       y = int'($urandom_range(127, 96));
          1:       y = 95;
          default: y = int'($urandom_range(15));
        endcase
        push(x, y, int'($urandom_range(3)), 1'b1, acc);
      end else tick();
    end
    vbi = 1'b1;
    drain(200);
    check("rand_mem", mem_mismatches(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
